wb_bus_arbiter: RTL
===================

Name: wb_bus_arbiter

Overview:
- Shares one Wishbone master port between the instruction-fetch port (IF stage) and the data port (MEM stage).
- Issues one bus cycle at a time and raises per-port stall requests toward the pipeline controller.
- Holds returned read data while the pipeline is stalled.
- Aborts in-flight cycles on flush, so exception handling and EX/MEM flushes stay consistent with bus state.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, ack timeout in cycles. Used only when WB_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  6  pipeline stall vector. Bit 0 is PC, up to bit 5 is WB.
- flush  in  1  pipeline flush.
- i_ce  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data.
- i_stallreq  out  1  stall request from the fetch port.
- d_ce  in  1  data request.
- d_we  in  1  data write.
- d_sel  in  4  byte lanes.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data.
- d_stallreq  out  1  stall request from the data port.
- wb_adr_o  out  ADDR_W
- wb_dat_o  out  DATA_W
- wb_dat_i  in  DATA_W
- wb_we_o  out  1
- wb_sel_o  out  4
- wb_stb_o  out  1
- wb_cyc_o  out  1
- wb_ack_i  in  1
- bus_err  out  1  one-cycle timeout pulse. Tied to 0 without the macro.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - all wb_* outputs are 0;
  - state is IDLE;
  - the hold buffer is 0;
  - i_rdata, d_rdata, stall requests and bus_err are 0.
- Reset mid-cycle drops cyc/stb at the same edge.
- States: IDLE, I_BUS, D_BUS, I_HOLD, D_HOLD.
- Bus outputs are registered. cyc and stb are driven together and held stable until ack.
- IDLE transitions, with flush=0:
  - d_ce=1: latch d_addr, d_wdata, d_we, d_sel; go to D_BUS.
  - else i_ce=1: latch i_addr, set we=0 and sel=4'hF; go to I_BUS.
  - Data wins a simultaneous request, because MEM is the older instruction.
- x_BUS with wb_ack_i=1:
  - drop cyc/stb next edge;
  - if stall==6'b0, go to IDLE;
  - else capture wb_dat_i into the hold buffer and go to x_HOLD.
- x_BUS with no ack: stay in x_BUS.
- x_HOLD: go to IDLE when stall==6'b0.
- Stall requests are combinational. Shown for the data port; the fetch port is symmetric.
  - d_stallreq=1 if d_ce=1 and flush=0 and any of:
    - state is IDLE;
    - state is I_BUS or I_HOLD;
    - state is D_BUS with wb_ack_i=0.
  - d_stallreq=0 otherwise. In particular it is 0 in D_BUS with ack and in D_HOLD.
- Read data, zero-latency on ack:
  - d_rdata = wb_dat_i when in D_BUS with ack;
  - d_rdata = hold buffer in D_HOLD;
  - d_rdata = 0 otherwise.
- Flush from any state:
  - go to IDLE at the next edge and deassert cyc/stb (Wishbone abort);
  - discard any ack arriving in the flush cycle;
  - clear the hold buffer;
  - both stall requests are 0 during the flush cycle.
- Starvation: a fetch waits at most one data cycle. The MEM stage cannot issue back-to-back without the pipeline advancing.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - a counter, cleared on entry to x_BUS, increments each cycle without ack;
  - at TIMEOUT_CYCLES the arbiter aborts the cycle, returns read data 0 on that port for one cycle as if acked, and pulses bus_err for one cycle;
  - next state follows the normal ack rules.
- Not defined: no counter; bus_err is tied to 0; the arbiter waits on ack indefinitely.

Decomposition:
- Shared package/defines header holds:
  - the state encodings;
  - WB_SEL_ALL (4'hF);
  - reuse of ZeroWord and the stall bit indices.
- One natural sub-module, wb_req_mux: a combinational request/priority select plus the bus-register load enable. The FSM stays in the top module.

Test Plan:
- Fetch only: i_ce=1, i_addr=0x100, slave acks on the 2nd bus cycle with 0xDEADBEEF, stall=0 → i_stallreq=1 until the ack cycle; i_rdata=0xDEADBEEF on the ack cycle; cyc=0 next cycle.
- Simultaneous: i_ce=d_ce=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_sel=4'hF → a data write is issued first with we=1; fetch starts the cycle after the data ack; i_stallreq is held throughout.
- Hold: fetch acked with 0xCAFEF00D while stall=6'b000011, stall held 3 cycles → I_HOLD; i_rdata=0xCAFEF00D, i_stallreq=0 for those 3 cycles; IDLE when stall=0.
- Flush mid-cycle: D_BUS, flush=1, ack in the same cycle → next cycle cyc=stb=0, state IDLE, d_rdata=0, no HOLD entry.
- Reset mid-cycle: I_BUS, rst=1 → next edge all wb_* outputs 0, i_stallreq=0; after release, a new i_ce restarts cleanly.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks → bus_err pulses once after 4 cycles; d_rdata=0; cyc dropped; d_stallreq=0 for that cycle.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and constants for the Wishbone fetch/data bus arbiter.
package wb_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUS  = 3'd1,
        D_BUS  = 3'd2,
        I_HOLD = 3'd3,
        D_HOLD = 3'd4
    } arb_state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam int STALL_PC = 0;
    localparam int STALL_WB = 5;

endpackage

// File: rtl/wb_bus_arbiter_req_mux.sv
// wb_req_mux: picks the winning request and builds the bus register load.
// Data wins ties because MEM holds the older instruction.
module wb_req_mux
    import wb_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              idle_i,
    input  logic              flush_i,
    input  logic              i_ce_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              d_ce_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              load_o,
    output logic              data_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              we_o,
    output logic [3:0]        sel_o
);

    assign load_o = idle_i & ~flush_i & (d_ce_i | i_ce_i);
    assign data_o = d_ce_i;

    always_comb begin
        adr_o = i_addr_i;
        dat_o = DATA_W'(ZeroWord);
        we_o  = 1'b0;
        sel_o = WB_SEL_ALL;
        unique case (1'b1)
            d_ce_i: begin
                adr_o = d_addr_i;
                dat_o = d_wdata_i;
                we_o  = d_we_i;
                sel_o = d_sel_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone master between fetch and data ports.
// Define WB_ARB_TIMEOUT_EN to abort unacked cycles after TIMEOUT_CYCLES.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WB:STALL_PC] stall,
    input  logic                   flush,
    input  logic                   i_ce,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [DATA_W-1:0]      i_rdata,
    output logic                   i_stallreq,
    input  logic                   d_ce,
    input  logic                   d_we,
    input  logic [3:0]             d_sel,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic [DATA_W-1:0]      d_rdata,
    output logic                   d_stallreq,
    output logic [ADDR_W-1:0]      wb_adr_o,
    output logic [DATA_W-1:0]      wb_dat_o,
    input  logic [DATA_W-1:0]      wb_dat_i,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic                   wb_stb_o,
    output logic                   wb_cyc_o,
    input  logic                   wb_ack_i,
    output logic                   bus_err
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic              cyc_q, cyc_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              mux_load, mux_data, mux_we;
    logic [ADDR_W-1:0] mux_adr;
    logic [DATA_W-1:0] mux_dat;
    logic [3:0]        mux_sel;

    logic              in_bus, timeout, ack_eff;
    logic [DATA_W-1:0] ack_data;

    wb_req_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_mux (
        .idle_i    (state_q == IDLE),
        .flush_i   (flush),
        .i_ce_i    (i_ce),
        .i_addr_i  (i_addr),
        .d_ce_i    (d_ce),
        .d_we_i    (d_we),
        .d_sel_i   (d_sel),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .load_o    (mux_load),
        .data_o    (mux_data),
        .adr_o     (mux_adr),
        .dat_o     (mux_dat),
        .we_o      (mux_we),
        .sel_o     (mux_sel)
    );

    assign in_bus = (state_q == I_BUS) || (state_q == D_BUS);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = in_bus && !wb_ack_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (in_bus && !wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus_err = timeout & ~flush & ~rst;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign ack_eff  = in_bus & (wb_ack_i | timeout);
    assign ack_data = timeout ? DATA_W'(ZeroWord) : wb_dat_i;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        hold_d  = hold_q;
        if (flush) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            hold_d  = DATA_W'(ZeroWord);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mux_load) begin
                        adr_d   = mux_adr;
                        dat_d   = mux_dat;
                        we_d    = mux_we;
                        sel_d   = mux_sel;
                        cyc_d   = 1'b1;
                        state_d = mux_data ? D_BUS : I_BUS;
                    end
                end
                I_BUS, D_BUS: begin
                    if (ack_eff) begin
                        cyc_d = 1'b0;
                        if (stall == '0) begin
                            state_d = IDLE;
                        end else begin
                            hold_d  = ack_data;
                            state_d = (state_q == I_BUS) ? I_HOLD : D_HOLD;
                        end
                    end
                end
                I_HOLD, D_HOLD: begin
                    if (stall == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            hold_q  <= hold_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

    // A flushed ack is discarded, so nothing reaches the ports that cycle.
    always_comb begin
        i_rdata = DATA_W'(ZeroWord);
        d_rdata = DATA_W'(ZeroWord);
        if (!rst && !flush) begin
            if (state_q == I_BUS && ack_eff) i_rdata = ack_data;
            if (state_q == I_HOLD)           i_rdata = hold_q;
            if (state_q == D_BUS && ack_eff) d_rdata = ack_data;
            if (state_q == D_HOLD)           d_rdata = hold_q;
        end
    end

    assign i_stallreq = i_ce & ~flush & ~rst &
                        ((state_q == IDLE) || (state_q == D_BUS) ||
                         (state_q == D_HOLD) ||
                         (state_q == I_BUS && !ack_eff));

    assign d_stallreq = d_ce & ~flush & ~rst &
                        ((state_q == IDLE) || (state_q == I_BUS) ||
                         (state_q == I_HOLD) ||
                         (state_q == D_BUS && !ack_eff));

endmodule
